bht_predictor: RTL and testbench
================================

# bht_predictor

Branch target buffer with 2-bit saturating direction counters, sitting in the fetch stage directly upstream of the decode/execute pipeline registers. Each cycle it supplies the predicted next PC (`pc_guessed`) and the counter state (`bht_state`) that travel with the instruction into the stage-2 register. When the execute stage resolves a branch or jump, it returns the outcome here to train the table. It also keeps resolved-branch and misprediction statistics.

## Interface
- `ADDR_BIT`, 10, width of the word-addressed instruction PC (matches `IM_ADDR_BIT`).
- `IDX_BIT`, 4, log2 of the table entry count (16 entries); index = `pc[IDX_BIT-1:0]`, tag = `pc[ADDR_BIT-1:IDX_BIT]`.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `flush`  in  1  synchronous invalidate of all entries (debug/self-modifying code).
- `pc`  in  ADDR_BIT  fetch PC for the lookup.
- `pc_guessed`  out  ADDR_BIT  predicted next PC.
- `bht_state`  out  2  counter state used for this prediction.
- `hit`  out  1  lookup tag matched a valid entry.
- `upd_en`  in  1  resolved control-transfer instruction leaving EX (already qualified by stall/clear).
- `upd_pc`  in  ADDR_BIT  PC of the resolved instruction.
- `upd_is_branch`  in  1  resolved instruction is a conditional branch.
- `upd_is_jump`  in  1  resolved instruction is an unconditional jump.
- `upd_taken`  in  1  actual direction (jumps always drive 1).
- `upd_target`  in  ADDR_BIT  actual target when taken.
- `upd_mispredict`  in  1  EX found that `pc_guessed` was wrong.
- `branch_cnt`  out  32  count of accepted updates.
- `mispred_cnt`  out  32  count of accepted updates with `upd_mispredict`=1.

## Operation
- Storage per entry: `valid`, `tag`, `target` (ADDR_BIT), `state` (2 bit). Encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup (combinational from registered table):
  - `hit` = valid & tag match.
  - `bht_state` = hit ? state : 01.
  - `pc_guessed` = (hit & state[1]) ? target : pc+1, modulo 2^ADDR_BIT, so PC all-ones wraps to 0.
- An update is accepted when `upd_en` & (`upd_is_branch` | `upd_is_jump`). Otherwise `upd_en` is ignored and no counter increments.
- Accepted update, entry at `upd_pc` index hits:
  - Branch: state += 1 if taken, saturating at 11; state −= 1 if not taken, saturating at 00.
  - Jump: state ← 11.
  - If taken, target ← `upd_target`.
  - Training uses the stored state, not the pipelined `bht_state` copy.
- Accepted update, entry misses:
  - Taken: allocate, overwriting any valid entry at that index. valid←1, tag, target←`upd_target`, state←(jump ? 11 : 10).
  - Not taken: no allocation, table unchanged.
- Accepted update: `branch_cnt` += 1; `mispred_cnt` += 1 if `upd_mispredict`. Both wrap modulo 2^32.
- `flush`: all valid ← 0 at the next edge. Counters are unaffected. `flush` has priority over a same-cycle update, so that update's table write is dropped; its counter increments still occur.

## Timing
- Lookup has zero latency: outputs follow `pc` combinationally in the same cycle.
- Update writes at the rising edge where it is accepted and is visible to lookups from the next cycle.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents. There is no bypass.
- Reset (asynchronous, any time, including mid-update): all valid bits 0, all states 01, targets/tags 0, both counters 0. Outputs during and after reset: `hit`=0, `bht_state`=01, `pc_guessed`=pc+1.
- No handshake; a single update port is accepted per cycle.

## Test plan
- Reset, then `pc`=0x005 → `hit`=0, `bht_state`=01, `pc_guessed`=0x006; `pc`=0x3FF → `pc_guessed`=0x000.
- Taken branch update `upd_pc`=0x012, `upd_target`=0x040 → next cycle `pc`=0x012 gives `hit`=1, `bht_state`=10, `pc_guessed`=0x040; `branch_cnt`=1.
- Two not-taken updates on 0x012 → state 10→01→00, `pc_guessed`=0x013; a third not-taken keeps 00. Three taken updates → 01, 10, 11; a fourth keeps 11.
- Alias: entry 0x012 valid, then taken jump update at 0x022 (same index, different tag) → lookup 0x012 misses, lookup 0x022 hits with state 11; a not-taken update at 0x032 allocates nothing.
- Same-cycle lookup and update at 0x012 → lookup returns old state; new state appears next cycle. `flush` with a same-cycle update → all misses afterwards, `branch_cnt` still incremented.
- `upd_en` with both type flags 0 → no table change, no count. Updates with `upd_mispredict`=1 on 3 of 5 accepted updates → `branch_cnt`=5, `mispred_cnt`=3. Assert `rst_n` mid-sequence → counters 0 and all lookups miss.

Source files
------------

// File: rtl/bht_predictor.sv
// Fetch-stage branch target buffer with 2-bit saturating direction counters.
// Zero-latency lookup on pc; training and statistics come back from execute.
module bht_predictor #(
    parameter int ADDR_BIT = 10,
    parameter int IDX_BIT  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic [ADDR_BIT-1:0] pc,
    output logic [ADDR_BIT-1:0] pc_guessed,
    output logic [1:0]          bht_state,
    output logic                hit,
    input  logic                upd_en,
    input  logic [ADDR_BIT-1:0] upd_pc,
    input  logic                upd_is_branch,
    input  logic                upd_is_jump,
    input  logic                upd_taken,
    input  logic [ADDR_BIT-1:0] upd_target,
    input  logic                upd_mispredict,
    output logic [31:0]         branch_cnt,
    output logic [31:0]         mispred_cnt
);
    localparam int ENTRIES = 1 << IDX_BIT;
    localparam int TAG_BIT = ADDR_BIT - IDX_BIT;

    logic                valid_q  [ENTRIES];
    logic [TAG_BIT-1:0]  tag_q    [ENTRIES];
    logic [ADDR_BIT-1:0] target_q [ENTRIES];
    logic [1:0]          state_q  [ENTRIES];

    logic [IDX_BIT-1:0]  rd_idx;
    logic [IDX_BIT-1:0]  wr_idx;
    logic [TAG_BIT-1:0]  rd_tag;
    logic [TAG_BIT-1:0]  wr_tag;
    logic                accept;
    logic                wr_hit;
    logic [1:0]          wr_state;
    logic [1:0]          state_nxt;

    assign rd_idx = pc[IDX_BIT-1:0];
    assign rd_tag = pc[ADDR_BIT-1:IDX_BIT];
    assign wr_idx = upd_pc[IDX_BIT-1:0];
    assign wr_tag = upd_pc[ADDR_BIT-1:IDX_BIT];

    assign hit        = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign bht_state  = hit ? state_q[rd_idx] : 2'b01;
    assign pc_guessed = (hit && state_q[rd_idx][1]) ? target_q[rd_idx] : pc + ADDR_BIT'(1);

    assign accept   = upd_en && (upd_is_branch || upd_is_jump);
    assign wr_hit   = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    assign wr_state = state_q[wr_idx];

    // Train from the stored counter, not the copy that travelled down the pipe.
    always_comb begin
        state_nxt = wr_state;
        if (upd_is_jump) begin
            state_nxt = 2'b11;
        end else if (upd_taken) begin
            if (wr_state != 2'b11) state_nxt = wr_state + 2'd1;
        end else begin
            if (wr_state != 2'b00) state_nxt = wr_state - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                state_q[i]  <= 2'b01;
            end
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
        end else if (accept) begin
            if (wr_hit) begin
                state_q[wr_idx] <= state_nxt;
                if (upd_taken) target_q[wr_idx] <= upd_target;
            end else if (upd_taken) begin
                valid_q[wr_idx]  <= 1'b1;
                tag_q[wr_idx]    <= wr_tag;
                target_q[wr_idx] <= upd_target;
                state_q[wr_idx]  <= upd_is_jump ? 2'b11 : 2'b10;
            end
        end
    end

    // Statistics count every accepted update, even one whose write a flush drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (accept) begin
            branch_cnt <= branch_cnt + 32'd1;
            if (upd_mispredict) mispred_cnt <= mispred_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_bht_predictor.sv
// Bench for bht_predictor: directed scenarios plus random traffic, all
// checked against an array-based model of the predictor table.
module tb_bht_predictor;
    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [9:0] pc = '0;
    logic [9:0] pc_guessed;
    logic [1:0] bht_state;
    logic       hit;
    logic       upd_en = 1'b0;
    logic [9:0] upd_pc = '0;
    logic       upd_is_branch = 1'b0;
    logic       upd_is_jump = 1'b0;
    logic       upd_taken = 1'b0;
    logic [9:0] upd_target = '0;
    logic       upd_mispredict = 1'b0;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    bht_predictor #(.ADDR_BIT(10), .IDX_BIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .pc(pc),
        .pc_guessed(pc_guessed), .bht_state(bht_state), .hit(hit),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
        .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_mispredict(upd_mispredict), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    bit          m_valid  [N];
    int          m_tag    [N];
    int          m_target [N];
    int          m_state  [N];
    bit [31:0]   m_bcnt;
    bit [31:0]   m_mcnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = 0; m_target[i] = 0; m_state[i] = 1;
        end
        m_bcnt = '0;
        m_mcnt = '0;
    endtask

    function automatic bit m_hit(input int p);
        return m_valid[p % N] && (m_tag[p % N] == p / N);
    endfunction

    function automatic int m_guess(input int p);
        if (m_hit(p) && m_state[p % N] >= 2) return m_target[p % N];
        return (p + 1) % 1024;
    endfunction

    // Applies whatever the inputs held at the edge that just passed.
    task automatic model_update();
        int idx, tg, p;
        bit acc;
        acc = upd_en && (upd_is_branch || upd_is_jump);
        if (acc) begin
            m_bcnt = m_bcnt + 1;
            if (upd_mispredict) m_mcnt = m_mcnt + 1;
        end
        if (flush) begin
            for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        end else if (acc) begin
            p = int'(upd_pc);
            idx = p % N;
            tg = p / N;
            if (m_hit(p)) begin
                if (upd_is_jump) m_state[idx] = 3;
                else if (upd_taken) m_state[idx] = (m_state[idx] == 3) ? 3 : m_state[idx] + 1;
                else m_state[idx] = (m_state[idx] == 0) ? 0 : m_state[idx] - 1;
                if (upd_taken) m_target[idx] = int'(upd_target);
            end else if (upd_taken) begin
                m_valid[idx] = 1'b1;
                m_tag[idx] = tg;
                m_target[idx] = int'(upd_target);
                m_state[idx] = upd_is_jump ? 3 : 2;
            end
        end
    endtask

    task automatic check_lookup(input string tag);
        int p;
        p = int'(pc);
        check({tag, ".hit"}, 64'(hit), 64'(m_hit(p)));
        check({tag, ".state"}, 64'(bht_state), m_hit(p) ? 64'(m_state[p % N]) : 64'd1);
        check({tag, ".guess"}, 64'(pc_guessed), 64'(m_guess(p)));
        check({tag, ".bcnt"}, 64'(branch_cnt), 64'(m_bcnt));
        check({tag, ".mcnt"}, 64'(mispred_cnt), 64'(m_mcnt));
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        check_lookup(tag);
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Constant expectations from the scenario list; called 1ns after an edge.
    task automatic peek(input string tag, input logic e_hit, input logic [1:0] e_st, input logic [9:0] e_g);
        #3;
        check({tag, ".hit"}, 64'(hit), 64'(e_hit));
        check({tag, ".state"}, 64'(bht_state), 64'(e_st));
        check({tag, ".guess"}, 64'(pc_guessed), 64'(e_g));
    endtask

    task automatic set_upd(input logic en, input logic br, input logic jp, input logic tk,
                           input logic [9:0] up, input logic [9:0] tgt, input logic mis);
        upd_en = en; upd_is_branch = br; upd_is_jump = jp; upd_taken = tk;
        upd_pc = up; upd_target = tgt; upd_mispredict = mis;
    endtask

    task automatic idle();
        set_upd(1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 10'h0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        idle();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst.hit", 64'(hit), 64'd0);
        check("rst.state", 64'(bht_state), 64'd1);
        check("rst.guess", 64'(pc_guessed), 64'(m_guess(int'(pc))));
        check("rst.bcnt", 64'(branch_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        pc = 10'h005;
        #3;
        check("por.hit", 64'(hit), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        pc = 10'h005; peek("r005", 1'b0, 2'b01, 10'h006); cycle("r005");
        pc = 10'h3FF; peek("r3ff", 1'b0, 2'b01, 10'h000); cycle("r3ff");

        pc = 10'h012;
        set_upd(1'b1, 1'b1, 1'b0, 1'b1, 10'h012, 10'h040, 1'b0);
        peek("alloc_same", 1'b0, 2'b01, 10'h013);
        cycle("alloc");
        idle();
        peek("alloc_after", 1'b1, 2'b10, 10'h040);
        check("alloc.bcnt", 64'(branch_cnt), 64'd1);
        cycle("alloc_after");

        set_upd(1'b1, 1'b1, 1'b0, 1'b0, 10'h012, 10'h0, 1'b0);
        cycle("nt1");
        peek("nt1", 1'b1, 2'b01, 10'h013);
        cycle("nt2");
        peek("nt2", 1'b1, 2'b00, 10'h013);
        cycle("nt3");
        peek("nt3", 1'b1, 2'b00, 10'h013);
        set_upd(1'b1, 1'b1, 1'b0, 1'b1, 10'h012, 10'h040, 1'b0);
        for (int k = 0; k < 4; k++) cycle("tk");
        idle();
        peek("tk_sat", 1'b1, 2'b11, 10'h040);

        set_upd(1'b1, 1'b0, 1'b1, 1'b1, 10'h022, 10'h100, 1'b0);
        cycle("jump");
        set_upd(1'b1, 1'b1, 1'b0, 1'b0, 10'h032, 10'h0, 1'b0);
        pc = 10'h012; peek("alias_old", 1'b0, 2'b01, 10'h013);
        cycle("nt032");
        idle();
        pc = 10'h022; peek("alias_new", 1'b1, 2'b11, 10'h100); cycle("alias_new");
        pc = 10'h032; peek("nt032", 1'b0, 2'b01, 10'h033); cycle("nt032_chk");

        pc = 10'h022;
        set_upd(1'b1, 1'b1, 1'b0, 1'b0, 10'h022, 10'h0, 1'b1);
        peek("same_old", 1'b1, 2'b11, 10'h100);
        cycle("same");
        idle();
        peek("same_new", 1'b1, 2'b10, 10'h100);

        flush = 1'b1;
        set_upd(1'b1, 1'b1, 1'b0, 1'b1, 10'h055, 10'h077, 1'b0);
        cycle("flush");
        flush = 1'b0;
        idle();
        pc = 10'h055; peek("flush_a", 1'b0, 2'b01, 10'h056); cycle("flush_a");
        pc = 10'h022; peek("flush_b", 1'b0, 2'b01, 10'h023); cycle("flush_b");

        set_upd(1'b1, 1'b0, 1'b0, 1'b1, 10'h022, 10'h111, 1'b1);
        cycle("notype");
        idle();
        peek("notype", 1'b0, 2'b01, 10'h023);
        cycle("notype_chk");

        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_upd(1'b1, 1'b1, 1'b0, k[0], 10'(k * 3), 10'h200, (k < 3));
            cycle("mis");
        end
        idle();
        #3;
        check("mis.bcnt", 64'(branch_cnt), 64'd5);
        check("mis.mcnt", 64'(mispred_cnt), 64'd3);
        cycle("mis_chk");

        for (int n = 0; n < 400; n++) begin
            logic jp;
            pc = {4'($urandom_range(0, 2)), 2'b00, 4'($urandom)};
            if ($urandom_range(0, 15) == 0) pc = 10'h3FF;
            jp = ($urandom_range(0, 4) == 0);
            set_upd($urandom_range(0, 3) != 0, !jp && ($urandom_range(0, 7) != 0), jp,
                    jp || $urandom_range(0, 1) == 1,
                    {4'($urandom_range(0, 2)), 2'b00, 4'($urandom)},
                    10'($urandom), 1'($urandom));
            flush = ($urandom_range(0, 39) == 0);
            if (n == 200) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                check("mid_rst.hit", 64'(hit), 64'd0);
                check("mid_rst.bcnt", 64'(branch_cnt), 64'd0);
                check("mid_rst.mcnt", 64'(mispred_cnt), 64'd0);
                check("mid_rst.guess", 64'(pc_guessed), 64'(m_guess(int'(pc))));
                idle();
                flush = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk);
                #1;
            end
            cycle("rand");
        end
        flush = 1'b0;
        idle();
        cycle("final");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
